// File: rtl/pentavium_ks_core.sv
// Pentavium keystream core: three radius-2 CA registers with cross feedback, packed valid/ready output.
// Optional build macro PENTAVIUM_RULE_CFG_EN adds a run-time rule schedule input (rule_cfg).
module pentavium_ks_core #(
    parameter int          KEY_W      = 80,
    parameter int          IV_W       = 80,
    parameter int          LA         = 93,
    parameter int          LB         = 84,
    parameter int          LC         = 111,
    parameter int          OUT_W      = 8,
    parameter int          INIT_STEPS = 1152,
    parameter logic [15:0] RULE_SCHED = 16'h78D2,
    parameter int          TAP_A      = 65,
    parameter int          TAP_B      = 68,
    parameter int          TAP_C      = 65,
    parameter int          XA         = 68,
    parameter int          XB         = 76,
    parameter int          XC         = 87
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key,
    input  logic [IV_W-1:0]  iv,
    input  logic             stop,
`ifdef PENTAVIUM_RULE_CFG_EN
    input  logic [15:0]      rule_cfg,
`endif
    output logic             busy,
    output logic             init_done,
    output logic [OUT_W-1:0] ks_data,
    output logic             ks_valid,
    input  logic             ks_ready,
    output logic [31:0]      word_cnt
);

    localparam int               CNT_W     = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OUT_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [31:0]      INIT_LAST = 32'(INIT_STEPS - 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_INIT = 2'd1, ST_GEN = 2'd2} state_e;

    state_e            state_q, state_d;
    logic [LA-1:0]     a_q, a_d;
    logic [LB-1:0]     b_q, b_d;
    logic [LC-1:0]     c_q, c_d;
    logic [OUT_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       step_q, step_d;
    logic [OUT_W-1:0]  ks_data_q, ks_data_d;
    logic              ks_valid_q, ks_valid_d;
    logic [31:0]       word_cnt_q, word_cnt_d;
    logic              busy_q, busy_d;
    logic              init_done_q, init_done_d;
    logic [15:0]       rule_s;

    function automatic logic ca_rule(input logic [1:0] rule, input logic m2, input logic m1,
                                     input logic s, input logic p1, input logic p2);
        logic r;
        case (rule)
            2'b00:   r = m2 ^ m1 ^ p1 ^ p2;
            2'b01:   r = m2 ^ m1 ^ s ^ p1 ^ p2;
            2'b10:   r = p2 ^ (p1 & s) ^ (p1 & m1) ^ s ^ m2 ^ 1'b1;
            default: r = p2 ^ (p1 & m1) ^ (s & m1) ^ m1 ^ m2;
        endcase
        return r;
    endfunction

`ifdef PENTAVIUM_RULE_CFG_EN
    logic [15:0] rule_q, rule_d;
    assign rule_s = rule_q;
`else
    assign rule_s = RULE_SCHED;
`endif

    // Null boundary: one zero above the top cell and two below cell 0; the top cell is shifted out.
    logic [LA+2:0] a_pad_s;
    logic [LB+2:0] b_pad_s;
    logic [LC+2:0] c_pad_s;
    logic [LA-2:0] ca_a_s;
    logic [LB-2:0] ca_b_s;
    logic [LC-2:0] ca_c_s;
    assign a_pad_s = {1'b0, a_q, 2'b00};
    assign b_pad_s = {1'b0, b_q, 2'b00};
    assign c_pad_s = {1'b0, c_q, 2'b00};

    // Parallel CA update of every retained cell of the three registers.
    always_comb begin
        ca_a_s = '0;
        ca_b_s = '0;
        ca_c_s = '0;
        for (int j = 0; j < LA - 1; j++) begin
            ca_a_s[j] = ca_rule(rule_s[2*(j%8) +: 2], a_pad_s[j], a_pad_s[j+1], a_pad_s[j+2], a_pad_s[j+3], a_pad_s[j+4]);
        end
        for (int j = 0; j < LB - 1; j++) begin
            ca_b_s[j] = ca_rule(rule_s[2*(j%8) +: 2], b_pad_s[j], b_pad_s[j+1], b_pad_s[j+2], b_pad_s[j+3], b_pad_s[j+4]);
        end
        for (int j = 0; j < LC - 1; j++) begin
            ca_c_s[j] = ca_rule(rule_s[2*(j%8) +: 2], c_pad_s[j], c_pad_s[j+1], c_pad_s[j+2], c_pad_s[j+3], c_pad_s[j+4]);
        end
    end

    logic t_a_s, t_b_s, t_c_s, z_s, f_a_s, f_b_s, f_c_s;
    assign t_a_s = a_q[TAP_A] ^ a_q[LA-1];
    assign t_b_s = b_q[TAP_B] ^ b_q[LB-1];
    assign t_c_s = c_q[TAP_C] ^ c_q[LC-1];
    assign z_s   = t_a_s ^ t_b_s ^ t_c_s;
    assign f_a_s = t_a_s ^ (a_q[LA-3] & a_q[LA-2]) ^ b_q[XB];
    assign f_b_s = t_b_s ^ (b_q[LB-3] & b_q[LB-2]) ^ c_q[XC];
    assign f_c_s = t_c_s ^ (c_q[LC-2] & c_q[LC-1]) ^ a_q[XA];

    // Control FSM, register stepping, word packing and output handshake.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        step_d     = step_q;
        ks_data_d  = ks_data_q;
        ks_valid_d = ks_valid_q;
        word_cnt_d = word_cnt_q;
`ifdef PENTAVIUM_RULE_CFG_EN
        rule_d     = rule_q;
`endif
        if (stop) begin
            state_d    = ST_IDLE;
            ks_valid_d = 1'b0;
            acc_d      = '0;
            cnt_d      = '0;
            step_d     = 32'd0;
            word_cnt_d = 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_d = '0;
                        a_d[KEY_W-1:0] = key;
                        b_d = '0;
                        b_d[IV_W-1:0] = iv;
                        c_d = '0;
                        c_d[LC-1:LC-3] = 3'b111;
                        acc_d      = '0;
                        cnt_d      = '0;
                        step_d     = 32'd0;
                        word_cnt_d = 32'd0;
                        state_d    = ST_INIT;
`ifdef PENTAVIUM_RULE_CFG_EN
                        rule_d     = rule_cfg;
`endif
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_INIT: begin
                    a_d = {ca_a_s, f_c_s};
                    b_d = {ca_b_s, f_a_s};
                    c_d = {ca_c_s, f_b_s};
                    if (step_q == INIT_LAST) begin
                        step_d  = 32'd0;
                        state_d = ST_GEN;
                    end else begin
                        step_d  = step_q + 32'd1;
                    end
                end
                ST_GEN: begin
                    if (ks_valid_q && ks_ready) begin
                        ks_valid_d = 1'b0;
                        word_cnt_d = word_cnt_q + 32'd1;
                    end else begin
                        ks_valid_d = ks_valid_q;
                    end
                    // A word-completing step waits until the output slot is free or being drained.
                    if (cnt_q == CNT_LAST) begin
                        if (!ks_valid_q || ks_ready) begin
                            a_d        = {ca_a_s, f_c_s};
                            b_d        = {ca_b_s, f_a_s};
                            c_d        = {ca_c_s, f_b_s};
                            ks_data_d  = acc_q;
                            ks_data_d[OUT_W-1] = z_s;
                            ks_valid_d = 1'b1;
                            acc_d      = '0;
                            cnt_d      = '0;
                        end else begin
                            a_d = a_q;
                        end
                    end else begin
                        a_d          = {ca_a_s, f_c_s};
                        b_d          = {ca_b_s, f_a_s};
                        c_d          = {ca_c_s, f_b_s};
                        acc_d[cnt_q] = z_s;
                        cnt_d        = cnt_q + CNT_ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d      = (state_d != ST_IDLE);
        init_done_d = (state_d == ST_GEN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            step_q      <= 32'd0;
            ks_data_q   <= '0;
            ks_valid_q  <= 1'b0;
            word_cnt_q  <= 32'd0;
            busy_q      <= 1'b0;
            init_done_q <= 1'b0;
`ifdef PENTAVIUM_RULE_CFG_EN
            rule_q      <= RULE_SCHED;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            ks_data_q   <= ks_data_d;
            ks_valid_q  <= ks_valid_d;
            word_cnt_q  <= word_cnt_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
`ifdef PENTAVIUM_RULE_CFG_EN
            rule_q      <= rule_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign init_done = init_done_q;
    assign ks_data   = ks_data_q;
    assign ks_valid  = ks_valid_q;
    assign word_cnt  = word_cnt_q;

endmodule
